// File: rtl/or_delay_pkg.sv
// Shared types and default sizing for the OR-gate delay scheduler.
package or_delay_pkg;

    localparam int unsigned DELAY_W_DEF = 4;
    localparam int unsigned DEPTH_DEF   = 4;
    // Countdown storage width; delays up to CNT_W bits are supported.
    localparam int unsigned CNT_W       = 16;

    typedef enum logic {
        MODE_INERTIAL  = 1'b0,
        MODE_TRANSPORT = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    typedef struct packed {
        logic             value;
        logic [CNT_W-1:0] countdown;
    } evt_t;

endpackage

// File: rtl/or_delay_evq.sv
// Circular event FIFO; every stored countdown ticks down once per cycle, saturating at zero.
module or_delay_evq
    import or_delay_pkg::*;
#(
    parameter int unsigned DELAY_W = DELAY_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   push_val,
    input  logic [DELAY_W-1:0]     push_dly,
    input  logic                   pop,
    input  logic                   flush,
    output evt_t                   head,
    output logic                   tail_val,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_WD = PTR_W + 1;

    evt_t             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign full     = (count == CNT_WD'(DEPTH));
    assign head     = mem[rd_ptr];
    assign tail_val = mem[wr_ptr - PTR_W'(1)].value;
    assign do_pop   = pop && (count != '0);
    // A pop frees the slot the same cycle, so a full queue still accepts.
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (mem[PTR_W'(i)].countdown != '0) begin
                    mem[PTR_W'(i)].countdown <= mem[PTR_W'(i)].countdown - CNT_W'(1);
                end
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= '{value: push_val, countdown: CNT_W'(push_dly)};
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_WD'(do_push) - CNT_WD'(do_pop);
            end
        end
    end

endmodule

// File: rtl/or_delay_scheduler.sv
// OR gate with inertial/transport propagation delay measured in clk cycles.
// Define OR_DELAY_SCHED_STATS_EN to add the cancel_cnt statistics output.
module or_delay_scheduler
    import or_delay_pkg::*;
#(
    parameter int unsigned DELAY_W = DELAY_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a,
    input  logic                   b,
    input  logic                   mode,
    input  logic [DELAY_W-1:0]     delay,
    output logic                   y,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   busy,
    output logic                   overflow
`ifdef OR_DELAY_SCHED_STATS_EN
    ,
    output logic [7:0]             cancel_cnt
`endif
);

    localparam int unsigned CNT_WD = $clog2(DEPTH) + 1;

    state_e              state;
    logic                mode_q;
    logic                z;
    logic                target;
    logic                fire;
    logic                push;
    logic                pop;
    logic                flush;
    logic                drop;
    logic                stat_evt;
    logic                full;
    logic                tail_val;
    logic [DELAY_W-1:0]  push_dly;
    logic [CNT_WD-1:0]   next_count;
    evt_t                head;

    or_delay_evq #(
        .DELAY_W (DELAY_W),
        .DEPTH   (DEPTH)
    ) u_evq (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_val (z),
        .push_dly (push_dly),
        .pop      (pop),
        .flush    (flush),
        .head     (head),
        .tail_val (tail_val),
        .count    (pending),
        .full     (full)
    );

    assign busy = (state == ST_PENDING);

    // Change detection and scheduling decisions for this cycle.
    always_comb begin
        z          = a | b;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        drop       = 1'b0;
        stat_evt   = 1'b0;
        push_dly   = (delay == '0) ? DELAY_W'(1) : delay;
        fire       = (pending != '0) && (head.countdown <= CNT_W'(1));
        target     = (pending != '0) ? tail_val : y;
        if (mode != mode_q) begin
            flush = 1'b1;
        end else if (mode_e'(mode) == MODE_TRANSPORT) begin
            pop = fire;
            if (z != target) begin
                if (full && !fire) begin
                    drop     = 1'b1;
                    stat_evt = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
        end else begin
            pop = fire;
            if (pending == '0) begin
                push = (z != target);
            end else if (z != target) begin
                // A firing event still lands; otherwise the pending one is cancelled.
                stat_evt = 1'b1;
                if (fire) begin
                    push = 1'b1;
                end else begin
                    flush = 1'b1;
                end
            end
        end
        next_count = flush ? '0 : pending + CNT_WD'(push) - CNT_WD'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y        <= 1'b0;
            overflow <= 1'b0;
            mode_q   <= mode;
            state    <= ST_IDLE;
        end else begin
            mode_q <= mode;
            if (pop) begin
                y <= head.value;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            case (state)
                ST_IDLE:    if (push) state <= ST_PENDING;
                ST_PENDING: if (next_count == '0) state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

`ifdef OR_DELAY_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cancel_cnt <= 8'd0;
        end else if (stat_evt && (cancel_cnt != 8'hFF)) begin
            cancel_cnt <= cancel_cnt + 8'd1;
        end
    end
`else
    logic unused_stat;
    assign unused_stat = stat_evt;
`endif

endmodule

// File: tb/tb_or_delay_scheduler.sv
// Directed bench for or_delay_scheduler: transport/inertial traces, overflow, delay 0, flush and reset.
module tb_or_delay_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       a;
    logic       b;
    logic       mode;
    logic [3:0] delay;
    logic       y;
    logic [2:0] pending;
    logic       busy;
    logic       overflow;
`ifdef OR_DELAY_SCHED_STATS_EN
    logic [7:0] cancel_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    or_delay_scheduler #(.DELAY_W(4), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .mode     (mode),
        .delay    (delay),
        .y        (y),
        .pending  (pending),
        .busy     (busy),
        .overflow (overflow)
`ifdef OR_DELAY_SCHED_STATS_EN
        ,
        .cancel_cnt (cancel_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic m, input logic [3:0] d);
        rst   = 1'b1;
        mode  = m;
        delay = d;
        a     = 1'b0;
        b     = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Shared a/b trace: {a,b} applied before edge t.
    function automatic logic [1:0] stim(input int t);
        if (t <= 3)  return 2'b11;
        if (t <= 6)  return 2'b10;
        if (t <= 10) return 2'b00;
        if (t <= 13) return 2'b01;
        return 2'b00;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] zpat;
        logic       exp_y;
        rst = 1'b1;
        a = 1'b0; b = 1'b0; mode = 1'b1; delay = 4'd3;

        // Reset state
        do_reset(1'b1, 4'd3);
        check_eq("rst_y", 32'(y), 32'd0);
        check_eq("rst_pending", 32'(pending), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);

        // Transport, delay 3
        for (int t = 0; t < 20; t++) begin
            {a, b} = stim(t);
            step();
            exp_y = ((t >= 3) && (t < 10)) || ((t >= 14) && (t < 17));
            check_eq($sformatf("tr3_y_t%0d", t), 32'(y), 32'(exp_y));
            if (t == 0) begin
                check_eq("tr3_pending_t0", 32'(pending), 32'd1);
                check_eq("tr3_busy_t0", 32'(busy), 32'd1);
            end
        end
        check_eq("tr3_pending_end", 32'(pending), 32'd0);

        // Inertial, delay 4: the 3-cycle b pulse is swallowed
        do_reset(1'b0, 4'd4);
        for (int t = 0; t < 20; t++) begin
            {a, b} = stim(t);
            step();
            exp_y = (t >= 4) && (t < 11);
            check_eq($sformatf("in4_y_t%0d", t), 32'(y), 32'(exp_y));
        end
        check_eq("in4_pending_end", 32'(pending), 32'd0);
`ifdef OR_DELAY_SCHED_STATS_EN
        check_eq("in4_cancel_cnt", 32'(cancel_cnt), 32'd2);
`endif

        // Transport overflow: DEPTH 4, delay 15, a toggles for 6 cycles
        do_reset(1'b1, 4'd15);
        for (int t = 0; t < 18; t++) begin
            a = (t < 6) ? ((t % 2) == 0) : 1'b0;
            b = 1'b0;
            step();
            exp_y = (t == 15) || (t == 17);
            check_eq($sformatf("ovf_y_t%0d", t), 32'(y), 32'(exp_y));
            if (t == 3) begin
                check_eq("ovf_pending_t3", 32'(pending), 32'd4);
                check_eq("ovf_flag_t3", 32'(overflow), 32'd0);
            end
            if (t == 4) begin
                check_eq("ovf_pending_t4", 32'(pending), 32'd4);
                check_eq("ovf_flag_t4", 32'(overflow), 32'd1);
            end
        end
        check_eq("ovf_pending_t17", 32'(pending), 32'd1);
        check_eq("ovf_flag_sticky", 32'(overflow), 32'd1);
`ifdef OR_DELAY_SCHED_STATS_EN
        check_eq("ovf_cancel_cnt", 32'(cancel_cnt), 32'd1);
`endif

        // Reset mid-queue clears everything in one cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_y", 32'(y), 32'd0);
        check_eq("midrst_pending", 32'(pending), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_overflow", 32'(overflow), 32'd0);
`ifdef OR_DELAY_SCHED_STATS_EN
        check_eq("midrst_cancel_cnt", 32'(cancel_cnt), 32'd0);
`endif

        // delay 0 behaves as 1 in both modes, including 1-cycle pulses
        zpat = 10'b01_0100_1101;
        for (int m = 1; m >= 0; m--) begin
            do_reset(1'(m), 4'd0);
            for (int t = 0; t < 11; t++) begin
                a = (t < 10) ? zpat[t] : 1'b0;
                b = 1'b0;
                step();
                exp_y = (t == 0) ? 1'b0 : zpat[t-1];
                check_eq($sformatf("d0_m%0d_y_t%0d", m, t), 32'(y), 32'(exp_y));
            end
        end

        // Delay change affects later events only; mode change flushes and holds y
        do_reset(1'b1, 4'd1);
        a = 1'b1; step();
        step();
        check_eq("mc_y_rise", 32'(y), 32'd1);
        delay = 4'd5;
        a = 1'b0; step();
        a = 1'b1; step();
        check_eq("mc_y_held_by_new_delay", 32'(y), 32'd1);
        a = 1'b0; step();
        check_eq("mc_pending3", 32'(pending), 32'd3);
        check_eq("mc_busy3", 32'(busy), 32'd1);
        mode = 1'b0;
        step();
        check_eq("mc_flush_pending", 32'(pending), 32'd0);
        check_eq("mc_flush_busy", 32'(busy), 32'd0);
        check_eq("mc_flush_y", 32'(y), 32'd1);
        step();
        check_eq("mc_after_y", 32'(y), 32'd1);
        check_eq("mc_after_pending", 32'(pending), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/or_delay_scheduler.md
OR_DELAY_SCHEDULER -- requirements
Module: or_delay_scheduler

Interface
REQ-001 SHALL have parameter DELAY_W, default 4, meaning delay field width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning transport event-queue entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports a, b  input  1 each  OR-gate operands, sampled every clk edge.
REQ-006 SHALL have port mode  input  1  0 = inertial, 1 = transport.
REQ-007 SHALL have port delay  input  DELAY_W  propagation delay in clk cycles; value 0 is treated as 1.
REQ-008 SHALL have port y  output  1  delayed OR result, registered.
REQ-009 SHALL have port pending  output  $clog2(DEPTH)+1  number of scheduled, not-yet-applied events.
REQ-010 SHALL have port busy  output  1  high when pending != 0.
REQ-011 SHALL have port overflow  output  1  sticky; set when a transport event is dropped.

Function
REQ-012 SHALL compute z = a|b each cycle; target = tail event value if pending != 0, else y; an event is scheduled only when z != target.
REQ-013 SHALL store each event as {value, countdown}; countdown is loaded with max(delay,1) at push and decremented each cycle, saturating at 0.
REQ-014 SHALL apply the head event (y <= value, pop) on the edge where its countdown is 1 or 0; latency from the a/b-sampling edge to the y change equals max(delay,1) cycles.
REQ-015 SHALL pop at most one event per cycle; later entries whose countdown already reached 0 fire on successive cycles, in FIFO order.
REQ-016 Transport mode SHALL queue every change, preserving pulses of any width >= 1 cycle.
REQ-017 Transport mode with the queue full and no pop that cycle SHALL drop the new event and set overflow; a simultaneous pop and push when full SHALL accept the push.
REQ-018 Inertial mode SHALL hold at most one event; a new change SHALL replace the pending event (new value, countdown reloaded).
REQ-019 Inertial mode with z returning to y while an event is pending SHALL cancel that event; pulses shorter than max(delay,1) cycles never reach y.
REQ-020 SHALL implement FSM states IDLE (queue empty) and PENDING; IDLE->PENDING on push; PENDING->IDLE on the last pop or cancel with no push.
REQ-021 A change of mode SHALL flush all pending events in that cycle, hold y, ignore that cycle's z comparison, and return to IDLE.
REQ-022 A change of delay SHALL affect only events pushed afterwards.
REQ-023 overflow SHALL clear only on rst.

Reset
REQ-024 On rst: y=0, pending=0, busy=0, overflow=0, queue emptied, FSM=IDLE; rst asserted mid-operation discards all events within one cycle.

Configuration
REQ-025 With OR_DELAY_SCHED_STATS_EN defined: add output cancel_cnt [7:0], counting inertial cancellations/replacements and transport drops, saturating at 255 and reset to 0.
REQ-026 Without OR_DELAY_SCHED_STATS_EN: port cancel_cnt and its logic are absent; all other behaviour is identical.

Structure
REQ-027 Package or_delay_pkg SHALL hold the mode enum (MODE_INERTIAL=0, MODE_TRANSPORT=1), FSM state enum, default DELAY_W/DEPTH constants and the event struct typedef.
REQ-028 The queue SHALL be a sub-module or_delay_evq (circular FIFO with per-entry countdown, push/pop/flush, count output); the top holds the FSM, change detection and y.

Verification
REQ-029 Transport, delay=3: a=b=1 at t0, a=1 b=0 at t4, both 0 at t7, b=1 at t11, both 0 at t14 -> y rises at t3, falls at t10, rises at t14, falls at t17.
REQ-030 Inertial, delay=4, same stimulus -> y rises at t4, falls at t11; the 3-cycle b pulse at t11-t13 is rejected; cancel_cnt=2 (STATS_EN).
REQ-031 Transport, DEPTH=4, delay=15, toggle a every cycle for 6 cycles -> pending saturates at 4, overflow=1, y reproduces the first 4 edges only.
REQ-032 delay=0 in either mode -> y follows z with exactly 1 cycle latency.
REQ-033 Transport with 3 events pending, switch mode -> pending=0, busy=0 next cycle, y unchanged; rst mid-queue -> all outputs 0 next cycle.
